// File: rtl/demux_1xn_stream_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the demux_1xn_stream block.
//   DEF_DATA_W / DEF_SEL_W / DEF_N_CH : default parameter values
//   CNT_W                             : width of each per-channel handshake
//                                       counter (DEMUX_CNT_EN builds only)
//   slice_base()                      : LSB position of channel k inside a
//                                       flattened N_CH*DATA_W bus
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 3;
    localparam int DEF_N_CH   = 8;
    localparam int CNT_W      = 16;

    function automatic int slice_base(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// ---------------------------------------------------------------------------
// demux_1xn_stream_if
// Producer-side and consumer-side stream signals of the 1-to-N demux.
//   in_valid/in_ready/in_data/in_sel/in_bcast : single input stream
//   out_valid/out_ready/out_data              : N_CH output streams,
//                                               channel k at
//                                               out_data[k*DATA_W +: DATA_W]
//   sel_err                                   : dropped-word pulse
// Modports:
//   slave  : the demux itself
//   master : the environment (producer + consumers)
// ---------------------------------------------------------------------------
interface demux_1xn_stream_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int N_CH   = 8
);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [N_CH-1:0]          out_valid;
    logic [N_CH-1:0]          out_ready;
    logic [N_CH*DATA_W-1:0]   out_data;
    logic                     sel_err;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

endinterface

// File: rtl/demux_1xn_stream_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry output register for a single demux channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data this cycle (wins over a drain)
//   load_data  : word to capture
//   ready      : consumer ready for this channel
//   valid      : slot holds a word
//   data       : held word, stable while valid && !ready
//   free       : slot can take a word this cycle (empty, or draining now)
// ---------------------------------------------------------------------------
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    // Drain and refill in the same cycle is allowed, so a full slot whose
    // consumer is ready counts as free.
    assign free  = ~valid_reg | ready;
    assign valid = valid_reg;
    assign data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1xn_stream.sv
// ---------------------------------------------------------------------------
// demux_1xn_stream
// Registered 1-to-N stream demultiplexer with a one-entry slot per channel.
// Each accepted word goes to channel in_sel, or to all channels when
// in_bcast=1 (all-or-nothing). Words with in_sel >= N_CH are accepted,
// discarded, and flagged by a one-cycle sel_err pulse on the next cycle.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : demux_1xn_stream_if.slave (input stream, N_CH output streams,
//             sel_err)
//   cnt_clr : synchronous clear of all handshake counters (DEMUX_CNT_EN)
//   cnt_out : N_CH x CNT_W handshake counters, channel k at
//             [k*CNT_W +: CNT_W] (DEMUX_CNT_EN)
//
// Optional feature macro: DEMUX_CNT_EN adds cnt_clr/cnt_out and counters.
// ---------------------------------------------------------------------------
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int N_CH   = DEF_N_CH
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef DEMUX_CNT_EN
    input  logic                  cnt_clr,
    output logic [N_CH*CNT_W-1:0] cnt_out,
`endif
    demux_1xn_stream_if.slave     bus
);

    logic [N_CH-1:0]        sel_hit;
    logic [N_CH-1:0]        free;
    logic [N_CH-1:0]        load;
    logic [N_CH-1:0]        slot_valid;
    logic [N_CH*DATA_W-1:0] slot_data;
    logic                   sel_in_range;
    logic                   sel_free;
    logic                   all_free;
    logic                   in_ready_comb;
    logic                   xfer;
    logic                   sel_err_next;
    logic                   sel_err_reg;

    genvar gi;

    // When N_CH fills the whole select space no index can be out of range;
    // the comparison is skipped so it does not degenerate to a constant.
    generate
        if (N_CH == (1 << SEL_W)) begin : g_full_range
            assign sel_in_range = 1'b1;
        end else begin : g_part_range
            assign sel_in_range = (int'(bus.in_sel) < N_CH);
        end
    endgenerate

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam int BASE = slice_base(gi, DATA_W);

            assign sel_hit[gi] = (bus.in_sel == SEL_W'(gi));
            assign load[gi]    = xfer & (bus.in_bcast | sel_hit[gi]);

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load[gi]),
                .load_data (bus.in_data),
                .ready     (bus.out_ready[gi]),
                .valid     (slot_valid[gi]),
                .data      (slot_data[BASE +: DATA_W]),
                .free      (free[gi])
            );
        end
    endgenerate

    // One-hot select masking avoids indexing free[] with a possibly
    // out-of-range in_sel.
    assign sel_free = |(free & sel_hit);
    assign all_free = &free;

    always_comb begin
        in_ready_comb = 1'b1;
        if (bus.in_bcast) begin
            in_ready_comb = all_free;
        end else if (sel_in_range) begin
            in_ready_comb = sel_free;
        end
    end

    assign xfer         = bus.in_valid & in_ready_comb;
    assign sel_err_next = xfer & ~bus.in_bcast & ~sel_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= sel_err_next;
        end
    end

    assign bus.in_ready  = in_ready_comb;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.sel_err   = sel_err_reg;

`ifdef DEMUX_CNT_EN
    // Per-channel completed-handshake counters; clear wins over increment,
    // and the counters wrap naturally at CNT_W bits.
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (slot_valid[gi] && bus.out_ready[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_out[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1xn_stream
// Drives one input stream into two demux instances (N_CH=8 and N_CH=6, both
// SEL_W=3) and checks them against a per-channel behavioural model.
// Optional feature macro: DEMUX_CNT_EN enables the counter checks.
// ---------------------------------------------------------------------------
module tb_demux_1xn_stream;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic [2:0] in_sel   = 3'd0;
    logic       in_bcast = 1'b0;
    logic [7:0] out_ready = 8'hFF;
    logic       cnt_clr   = 1'b0;

    always #5 clk = ~clk;

    demux_1xn_stream_if #(.DATA_W(8), .SEL_W(3), .N_CH(8)) bus8 ();
    demux_1xn_stream_if #(.DATA_W(8), .SEL_W(3), .N_CH(6)) bus6 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_data   = in_data;
    assign bus8.in_sel    = in_sel;
    assign bus8.in_bcast  = in_bcast;
    assign bus8.out_ready = out_ready;
    assign bus6.in_valid  = in_valid;
    assign bus6.in_data   = in_data;
    assign bus6.in_sel    = in_sel;
    assign bus6.in_bcast  = in_bcast;
    assign bus6.out_ready = out_ready[5:0];

`ifdef DEMUX_CNT_EN
    logic [8*16-1:0] cnt8;
    logic [6*16-1:0] cnt6;
`endif

    demux_1xn_stream #(.DATA_W(8), .SEL_W(3), .N_CH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DEMUX_CNT_EN
        .cnt_clr (cnt_clr),
        .cnt_out (cnt8),
`endif
        .bus     (bus8)
    );

    demux_1xn_stream #(.DATA_W(8), .SEL_W(3), .N_CH(6)) dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DEMUX_CNT_EN
        .cnt_clr (cnt_clr),
        .cnt_out (cnt6),
`endif
        .bus     (bus6)
    );

    // ---------------- reference model ----------------
    int         nch [2] = '{8, 6};
    bit         m_full [2][8];
    logic [7:0] m_data [2][8];
    bit         m_err  [2];
    int         m_cnt  [2][8];
    bit         exp_rdy [2];
    bit         acc     [2];

    int tests = 0;
    int fails = 0;
    bit quiet = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        if (quiet) return;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_valid(input int d);
        if (d == 0) return bus8.out_valid;
        return {2'b00, bus6.out_valid};
    endfunction

    function automatic logic [7:0] obs_data(input int d, input int k);
        if (d == 0) return bus8.out_data[k*8 +: 8];
        return bus6.out_data[k*8 +: 8];
    endfunction

    function automatic logic obs_err(input int d);
        if (d == 0) return bus8.sel_err;
        return bus6.sel_err;
    endfunction

`ifdef DEMUX_CNT_EN
    function automatic logic [15:0] obs_cnt(input int d, input int k);
        if (d == 0) return cnt8[k*16 +: 16];
        return cnt6[k*16 +: 16];
    endfunction
`endif

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            acc[d]   = 1'b0;
            for (int k = 0; k < 8; k++) begin
                m_full[d][k] = 1'b0;
                m_data[d][k] = 8'h00;
                m_cnt[d][k]  = 0;
            end
        end
    endtask

    task automatic set_in(input bit v, input int sel, input logic [7:0] dat, input bit bc);
        in_valid = v;
        in_sel   = 3'(sel);
        in_data  = dat;
        in_bcast = bc;
    endtask

    // Called a couple of ns after a rising edge once inputs are set: work out
    // what each instance should accept and compare in_ready.
    task automatic settle();
        bit all_free;
        int s;
        #1;
        s = int'(in_sel);
        for (int d = 0; d < 2; d++) begin
            all_free = 1'b1;
            for (int k = 0; k < nch[d]; k++)
                if (m_full[d][k] && !out_ready[k]) all_free = 1'b0;
            if (in_bcast)          exp_rdy[d] = all_free;
            else if (s >= nch[d])  exp_rdy[d] = 1'b1;
            else                   exp_rdy[d] = !m_full[d][s] || out_ready[s];
            acc[d] = in_valid && exp_rdy[d];
        end
        chk("in_ready_n8", bus8.in_ready, exp_rdy[0]);
        chk("in_ready_n6", bus6.in_ready, exp_rdy[1]);
    endtask

    task automatic check_outputs();
        logic [7:0] ev;
        for (int d = 0; d < 2; d++) begin
            ev = 8'h00;
            for (int k = 0; k < nch[d]; k++) ev[k] = m_full[d][k];
            chk($sformatf("out_valid_n%0d", nch[d]), obs_valid(d), ev);
            for (int k = 0; k < nch[d]; k++)
                if (m_full[d][k])
                    chk($sformatf("out_data_n%0d_ch%0d", nch[d], k), obs_data(d, k), m_data[d][k]);
            chk($sformatf("sel_err_n%0d", nch[d]), obs_err(d), m_err[d]);
`ifdef DEMUX_CNT_EN
            for (int k = 0; k < nch[d]; k++)
                chk($sformatf("cnt_n%0d_ch%0d", nch[d], k), obs_cnt(d, k), 64'(m_cnt[d][k]));
`endif
        end
    endtask

    // Advance the model by the rules for this cycle's inputs, take the edge,
    // then compare the registered outputs.
    task automatic clock();
        bit drain;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nch[d]; k++) begin
                drain = m_full[d][k] && out_ready[k];
                if (cnt_clr)    m_cnt[d][k] = 0;
                else if (drain) m_cnt[d][k] = (m_cnt[d][k] + 1) % 65536;
                if (acc[d] && (in_bcast || int'(in_sel) == k)) begin
                    m_full[d][k] = 1'b1;
                    m_data[d][k] = in_data;
                end else if (drain) begin
                    m_full[d][k] = 1'b0;
                end
            end
            m_err[d] = acc[d] && !in_bcast && (int'(in_sel) >= nch[d]);
        end
        @(posedge clk);
        #2;
        check_outputs();
    endtask

    task automatic cycle();
        settle();
        clock();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // Reset state, sampled while rst_n is still low.
        #12;
        chk("rst_out_valid_n8", bus8.out_valid, 8'h00);
        chk("rst_out_data_n8",  bus8.out_data, 64'h0);
        chk("rst_sel_err_n8",   bus8.sel_err, 1'b0);
        chk("rst_in_ready_n8",  bus8.in_ready, 1'b1);
        chk("rst_out_valid_n6", bus6.out_valid, 6'h00);
        chk("rst_in_ready_n6",  bus6.in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Idle with every consumer ready.
        out_ready = 8'hFF;
        repeat (3) cycle();

        // Unicast streaming to channel 5.
        set_in(1, 5, 8'h11, 0); cycle();
        chk("t2_valid", bus8.out_valid, 8'h20);
        chk("t2_data0", bus8.out_data[5*8 +: 8], 8'h11);
        set_in(1, 5, 8'h22, 0); cycle();
        chk("t2_data1", bus8.out_data[5*8 +: 8], 8'h22);
        set_in(1, 5, 8'h33, 0); cycle();
        chk("t2_data2", bus8.out_data[5*8 +: 8], 8'h33);
        set_in(0, 0, 8'h00, 0); cycle();
        cycle();

        // Backpressure on channel 2.
        out_ready = 8'hFB;
        set_in(1, 2, 8'hA5, 0); cycle();
        set_in(1, 2, 8'h3C, 0); settle();
        chk("t3_stall", bus8.in_ready, 1'b0);
        clock();
        chk("t3_hold", bus8.out_data[2*8 +: 8], 8'hA5);
        cycle();
        out_ready = 8'hFF; settle();
        chk("t3_release", bus8.in_ready, 1'b1);
        clock();
        chk("t3_second", bus8.out_data[2*8 +: 8], 8'h3C);
        set_in(0, 0, 8'h00, 0); cycle();

        // Broadcast blocked by a stalled, full channel 7.
        out_ready = 8'h7F;
        set_in(1, 7, 8'h77, 0); cycle();
        set_in(1, 0, 8'h5A, 1); settle();
        chk("t4_stall", bus8.in_ready, 1'b0);
        clock();
        chk("t4_no_partial", bus8.out_valid, 8'h80);
        cycle();
        out_ready = 8'hFF; settle();
        chk("t4_release", bus8.in_ready, 1'b1);
        clock();
        chk("t4_all_valid", bus8.out_valid, 8'hFF);
        chk("t4_ch3", bus8.out_data[3*8 +: 8], 8'h5A);
        set_in(0, 0, 8'h00, 0); cycle();
        cycle();

        // Out-of-range select on the six-channel instance.
        set_in(1, 6, 8'hFF, 0); settle();
        chk("t5_ready", bus6.in_ready, 1'b1);
        clock();
        chk("t5_err", bus6.sel_err, 1'b1);
        chk("t5_no_valid", bus6.out_valid, 6'h00);
        set_in(0, 0, 8'h00, 0); cycle();
        chk("t5_err_once", bus6.sel_err, 1'b0);

        // Randomised traffic; a stalled word is held until accepted.
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || acc[0])
                set_in($urandom_range(0, 9) < 7, $urandom_range(0, 7), 8'($urandom),
                       $urandom_range(0, 6) == 0);
            if ((i % 300) < 80) out_ready = 8'($urandom) & 8'($urandom);
            else                out_ready = 8'($urandom) | 8'($urandom);
            cnt_clr = ($urandom_range(0, 59) == 0);
            cycle();
        end
        cnt_clr = 1'b0;

        // Asynchronous reset in the middle of traffic.
        out_ready = 8'h00;
        set_in(1, 1, 8'h99, 0); cycle();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid_n8", bus8.out_valid, 8'h00);
        chk("arst_out_data_n8",  bus8.out_data, 64'h0);
        chk("arst_sel_err_n6",   bus6.sel_err, 1'b0);
        chk("arst_out_valid_n6", bus6.out_valid, 6'h00);
`ifdef DEMUX_CNT_EN
        chk("arst_cnt_n8", cnt8[63:0], 64'h0);
`endif
        model_reset();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        set_in(0, 0, 8'h00, 0);
        cycle();

`ifdef DEMUX_CNT_EN
        // Three handshakes on channel 0.
        repeat (3) begin
            set_in(1, 0, 8'($urandom), 0); cycle();
        end
        set_in(0, 0, 8'h00, 0); cycle();
        cycle();
        chk("c_three", cnt8[15:0], 16'd3);

        // Clear, then 65536 handshakes wrap back to zero.
        cnt_clr = 1'b1; cycle();
        cnt_clr = 1'b0;
        quiet = 1'b1;
        set_in(1, 0, 8'h42, 0);
        repeat (65536) cycle();
        quiet = 1'b0;
        check_outputs();
        chk("c_ffff", cnt8[15:0], 16'hFFFF);
        set_in(0, 0, 8'h00, 0); cycle();
        chk("c_wrap", cnt8[15:0], 16'h0000);

        // Clear coinciding with a handshake.
        set_in(1, 0, 8'h24, 0); cycle();
        set_in(0, 0, 8'h00, 0);
        cnt_clr = 1'b1; cycle();
        cnt_clr = 1'b0;
        chk("c_clr_wins", cnt8[15:0], 16'h0000);
        cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
